// File: rtl/lstm_fwd_seq.sv
// Forward-pass sequencer for the LSTM stage: zero-fills the t=-1 H/C slot,
// then runs accumulate / drain / commit for every (timestep, cell) pair.
module lstm_fwd_seq #(
    parameter int ADDR_WIDTH = 12,
    parameter int TIMESTEP   = 7,
    parameter int NUM_CELL   = 8,
    parameter int NUM_INPUT  = 53,
    parameter int DELAY      = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  en_addr,
    output logic                  acc_clr,
    output logic                  acc_en,
    output logic                  src_sel,
    output logic                  wr_en,
    output logic                  wr_zero,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH-1:0] t_idx,
    output logic [ADDR_WIDTH-1:0] cell_idx
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        LOAD,
        MAC,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE        = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] NCELL      = ADDR_WIDTH'(NUM_CELL);
    localparam logic [ADDR_WIDTH-1:0] CELL_LAST  = ADDR_WIDTH'(NUM_CELL - 1);
    localparam logic [ADDR_WIDTH-1:0] T_LAST     = ADDR_WIDTH'(TIMESTEP - 1);
    localparam logic [ADDR_WIDTH-1:0] MAC_LAST   = ADDR_WIDTH'(NUM_INPUT + NUM_CELL - 1);
    localparam logic [ADDR_WIDTH-1:0] SRC_SPLIT  = ADDR_WIDTH'(NUM_INPUT);
    localparam logic [ADDR_WIDTH-1:0] DRAIN_LAST = ADDR_WIDTH'(DELAY - 1);

    state_t state, state_n;
    logic [ADDR_WIDTH-1:0] cnt, cnt_n;
    logic [ADDR_WIDTH-1:0] t_cnt, t_n;
    logic [ADDR_WIDTH-1:0] c_cnt, c_n;

    logic                  busy_d;
    logic                  done_d;
    logic                  en_addr_d;
    logic                  acc_clr_d;
    logic                  acc_en_d;
    logic                  src_sel_d;
    logic                  wr_en_d;
    logic                  wr_zero_d;
    logic [ADDR_WIDTH-1:0] wr_addr_d;

    // State, counters and the output flops; outputs are decoded from the
    // next state so every strobe lines up with the state it belongs to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            t_cnt   <= '0;
            c_cnt   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            en_addr <= 1'b0;
            acc_clr <= 1'b0;
            acc_en  <= 1'b0;
            src_sel <= 1'b0;
            wr_en   <= 1'b0;
            wr_zero <= 1'b0;
            wr_addr <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            t_cnt   <= t_n;
            c_cnt   <= c_n;
            busy    <= busy_d;
            done    <= done_d;
            en_addr <= en_addr_d;
            acc_clr <= acc_clr_d;
            acc_en  <= acc_en_d;
            src_sel <= src_sel_d;
            wr_en   <= wr_en_d;
            wr_zero <= wr_zero_d;
            wr_addr <= wr_addr_d;
        end
    end

    assign t_idx    = t_cnt;
    assign cell_idx = c_cnt;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        t_n     = t_cnt;
        c_n     = c_cnt;
        if (state != IDLE && abort) begin
            state_n = IDLE;
            cnt_n   = '0;
            t_n     = '0;
            c_n     = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start && !abort) begin
                        state_n = INIT;
                        cnt_n   = '0;
                        t_n     = '0;
                        c_n     = '0;
                    end
                end
                INIT: begin
                    if (cnt == CELL_LAST) begin
                        state_n = LOAD;
                        cnt_n   = '0;
                        t_n     = '0;
                        c_n     = '0;
                    end else begin
                        cnt_n = cnt + ONE;
                    end
                end
                LOAD: begin
                    state_n = MAC;
                    cnt_n   = '0;
                end
                MAC: begin
                    if (cnt == MAC_LAST) begin
                        state_n = DRAIN;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + ONE;
                    end
                end
                DRAIN: begin
                    if (cnt == DRAIN_LAST) begin
                        state_n = WRITE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + ONE;
                    end
                end
                WRITE: begin
                    cnt_n = '0;
                    if (c_cnt < CELL_LAST) begin
                        state_n = LOAD;
                        c_n     = c_cnt + ONE;
                    end else if (t_cnt < T_LAST) begin
                        state_n = LOAD;
                        c_n     = '0;
                        t_n     = t_cnt + ONE;
                    end else begin
                        state_n = DONE;
                    end
                end
                DONE: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    t_n     = '0;
                    c_n     = '0;
                end
                default: begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    t_n     = '0;
                    c_n     = '0;
                end
            endcase
        end
    end

    // Slot 0 of H/C holds the t=-1 zeros, so timestep t lands in slot t+1.
    always_comb begin
        busy_d    = (state_n != IDLE);
        done_d    = (state_n == DONE);
        acc_clr_d = (state_n == LOAD);
        acc_en_d  = (state_n == MAC);
        en_addr_d = (state_n == MAC);
        src_sel_d = (state_n == MAC) && (cnt_n >= SRC_SPLIT);
        wr_en_d   = (state_n == INIT) || (state_n == WRITE);
        wr_zero_d = (state_n == INIT);
        wr_addr_d = '0;
        if (state_n == INIT) begin
            wr_addr_d = cnt_n;
        end else if (state_n == WRITE) begin
            wr_addr_d = NCELL * (t_n + ONE) + c_n;
        end
    end

endmodule

// File: tb/tb_lstm_fwd_seq.sv
// Directed bench for lstm_fwd_seq: scoreboard of expected H/C writes with
// cycle stamps, plus abort, restart and mid-pass reset scenarios.
module tb_lstm_fwd_seq;

    localparam int AW   = 12;
    localparam int TS   = 7;
    localparam int NC   = 8;
    localparam int NI   = 53;
    localparam int DL   = 3;
    localparam int CELL_CYC = 2 + NI + NC + DL;
    localparam int DONE_CYC = 1 + NC + TS * NC * CELL_CYC;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          en_addr;
    logic          acc_clr;
    logic          acc_en;
    logic          src_sel;
    logic          wr_en;
    logic          wr_zero;
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] t_idx;
    logic [AW-1:0] cell_idx;

    always #5 clk = ~clk;

    lstm_fwd_seq #(
        .ADDR_WIDTH(AW),
        .TIMESTEP  (TS),
        .NUM_CELL  (NC),
        .NUM_INPUT (NI),
        .DELAY     (DL)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .busy    (busy),
        .done    (done),
        .en_addr (en_addr),
        .acc_clr (acc_clr),
        .acc_en  (acc_en),
        .src_sel (src_sel),
        .wr_en   (wr_en),
        .wr_zero (wr_zero),
        .wr_addr (wr_addr),
        .t_idx   (t_idx),
        .cell_idx(cell_idx)
    );

    typedef struct {
        int addr;
        bit zero;
        int t;
        int c;
        int cyc;
    } wr_t;

    wr_t sbq[$];
    int checks   = 0;
    int failures = 0;
    int done_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_strobes"}, {en_addr, acc_clr, acc_en, src_sel, wr_en, wr_zero}, 0);
        chk({tag, "_wr_addr"}, wr_addr, 0);
        chk({tag, "_idx"}, {t_idx, cell_idx}, 0);
    endtask

    task automatic push_pass();
        wr_t e;
        sbq.delete();
        for (int i = 0; i < NC; i++) begin
            e = '{addr: i, zero: 1'b1, t: 0, c: 0, cyc: 1 + i};
            sbq.push_back(e);
        end
        for (int k = 0; k < TS * NC; k++) begin
            e = '{addr: NC * (k / NC + 1) + k % NC, zero: 1'b0,
                  t: k / NC, c: k % NC, cyc: 1 + NC + CELL_CYC * k + CELL_CYC - 1};
            sbq.push_back(e);
        end
    endtask

    task automatic monitor(input int cyc);
        wr_t e;
        chk("busy", busy, (cyc >= 1 && cyc <= DONE_CYC));
        chk("done", done, (cyc == DONE_CYC));
        if (done === 1'b1) done_cnt++;
        if (wr_en === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("wr_unexpected", wr_en, 0);
            end else begin
                e = sbq.pop_front();
                chk("wr_addr", wr_addr, e.addr);
                chk("wr_zero", wr_zero, e.zero);
                chk("wr_cycle", cyc, e.cyc);
                if (!e.zero) begin
                    chk("wr_t_idx", t_idx, e.t);
                    chk("wr_cell_idx", cell_idx, e.c);
                end
            end
        end
        if (cyc >= 1 + NC && cyc < 1 + NC + CELL_CYC) begin
            chk("c0_acc_clr", acc_clr, (cyc == 1 + NC));
            chk("c0_acc_en", acc_en, (cyc >= 2 + NC && cyc < 2 + NC + NI + NC));
            chk("c0_en_addr", en_addr, (cyc >= 2 + NC && cyc < 2 + NC + NI + NC));
            chk("c0_src_sel", src_sel, (cyc >= 2 + NC + NI && cyc < 2 + NC + NI + NC));
            chk("c0_wr_en", wr_en, (cyc == NC + CELL_CYC));
        end
    endtask

    // Start in cycle 0, optionally re-pulse start at restart_at.
    task automatic run_full(input int restart_at);
        push_pass();
        done_cnt = 0;
        @(posedge clk);
        #1 start = 1'b1;
        for (int cyc = 1; cyc <= DONE_CYC + 3; cyc++) begin
            @(posedge clk);
            #1 start = (cyc == restart_at);
            @(negedge clk);
            monitor(cyc);
        end
        chk("sb_drained", sbq.size(), 0);
        chk("done_pulses", done_cnt, 1);
    endtask

    // Start a pass, then in cycle stop_at assert abort or rst.
    task automatic run_until(input int stop_at, input bit use_rst);
        push_pass();
        done_cnt = 0;
        @(posedge clk);
        #1 start = 1'b1;
        for (int cyc = 1; cyc < stop_at; cyc++) begin
            @(posedge clk);
            #1 start = 1'b0;
            @(negedge clk);
            monitor(cyc);
        end
        @(posedge clk);
        #1;
        if (use_rst) rst = 1'b1;
        else abort = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk_zero(use_rst ? "rst_mid" : "abort_mid");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("stop_busy", busy, 0);
            chk("stop_done", done, 0);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_zero("reset");
        @(posedge clk);
        #1 rst = 1'b0;

        start = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk_zero("start_abort_idle");

        run_full(0);
        run_full(500);
        run_until(1000, 1'b0);
        run_full(0);
        run_until(30, 1'b1);
        run_full(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
